// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared state type and default constants for the NTT stage controller
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_state_t;

    localparam int DEFAULT_RING_SIZE  = 256;
    localparam int DEFAULT_LANES      = 1;
    localparam int INTMUL_DELAY       = 6;
    localparam int MODRED_DELAY       = 5;
    localparam int DEFAULT_PIPE_DELAY = INTMUL_DELAY + MODRED_DELAY;

endpackage

// File: rtl/ntt_delay_line.sv
// rtl/ntt_delay_line.sv - fixed-depth shift register with synchronous clear
module ntt_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    // Shift one tap per cycle; clear wipes every tap so nothing in flight survives
    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/ntt_stage_controller.sv
// rtl/ntt_stage_controller.sv - stage/issue sequencer for an in-place NTT butterfly datapath
module ntt_stage_controller
    import ntt_pkg::*;
#(
    parameter int RING_SIZE  = DEFAULT_RING_SIZE,
    parameter int LANES      = DEFAULT_LANES,
    parameter int PIPE_DELAY = DEFAULT_PIPE_DELAY,
    localparam int LOG_N     = $clog2(RING_SIZE),
    localparam int STAGE_W   = $clog2(LOG_N + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               inverse,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               sel_a,
    output logic               sel_b,
    output logic               sel_ram,
    output logic [STAGE_W-1:0] stage,
    output logic [LOG_N-2:0]   bfly_idx,
    output logic [LOG_N-1:0]   tw_addr,
    output logic               wr_en
);

    localparam int BF      = RING_SIZE / (2 * LANES);
    localparam int CNT_W   = LOG_N - 1;
    localparam int LANE_SH = $clog2(LANES);
    localparam int DCNT_W  = (PIPE_DELAY > 1) ? $clog2(PIPE_DELAY) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(BF - 1);
    localparam logic [DCNT_W-1:0]  DCNT_LAST  = DCNT_W'(PIPE_DELAY - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG_N - 1);
    localparam logic [LOG_N-1:0]   TW_HALF    = LOG_N'(RING_SIZE / 2);

    ntt_state_t         r_state;
    logic [STAGE_W-1:0] r_stage;
    logic [CNT_W-1:0]   r_cnt;
    logic [DCNT_W-1:0]  r_dcnt;
    logic               r_inverse;

    logic               w_issue;
    logic               w_clr;
    logic [LOG_N-1:0]   w_mask;
    logic [STAGE_W-1:0] w_shamt;
    logic [LOG_N-1:0]   w_tw;

    // Sequencer: issue BF butterflies per stage, then wait out the datapath latency
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_stage   <= '0;
            r_cnt     <= '0;
            r_dcnt    <= '0;
            r_inverse <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_stage <= '0;
                    r_cnt   <= '0;
                    if (start) begin
                        r_inverse <= inverse;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == CNT_LAST) begin
                        r_dcnt  <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_dcnt == DCNT_LAST) begin
                        if (r_stage < STAGE_LAST) begin
                            r_stage <= r_stage + STAGE_W'(1);
                            r_cnt   <= '0;
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + DCNT_W'(1);
                    end
                end
                default: begin
                    r_stage <= '0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Twiddle index: low 'stage' bits of the butterfly index, scaled up to the ROM stride
    always_comb begin
        w_mask  = (LOG_N'(1) << r_stage) - LOG_N'(1);
        w_shamt = STAGE_LAST - r_stage;
        w_tw    = (({1'b0, bfly_idx} & w_mask) << w_shamt) + (r_inverse ? TW_HALF : '0);
    end

    assign w_issue  = (r_state == ST_RUN);
    assign w_clr    = !reset_n;

    assign ready    = (r_state == ST_IDLE);
    assign busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done     = (r_state == ST_DONE);
    assign sel_a    = !w_issue || !r_cnt[0];
    assign sel_b    = !w_issue || r_cnt[0];
    assign sel_ram  = (r_stage == '0);
    assign stage    = r_stage;
    assign bfly_idx = r_cnt << LANE_SH;
    assign tw_addr  = w_tw;

    ntt_delay_line #(
        .WIDTH (1),
        .DEPTH (PIPE_DELAY)
    ) u_wr_dly (
        .clk   (clk),
        .i_clr (w_clr),
        .i_d   (w_issue),
        .o_q   (wr_en)
    );

endmodule
